bcd_lap_counter: RTL and testbench
==================================

Name: bcd_lap_counter

Overview:
- Parametrised successor to the millisecond event counter.
- Built-in prescaler generates the count tick from the system clock.
- Counts in packed BCD with DIGITS digits, so the value drives the HEX display decoders directly.
- Adds run/pause/clear control, a lap-capture register, and selectable wrap or saturate at full scale.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- TICK_HZ, 1000, count rate. DIV = CLK_FREQ_HZ/TICK_HZ, integer and >= 2; elaboration fails otherwise.
- DIGITS, 6, number of BCD digits (1..8).
- WRAP, 1, full-scale policy: 1 = wrap to zero, 0 = saturate at all nines.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- clear  in  1  synchronous clear of count, lap, prescaler and overflow; returns to IDLE
- start  in  1  level/pulse; IDLE or PAUSE -> RUN
- stop  in  1  level/pulse; RUN -> PAUSE
- lap  in  1  capture current count into lap_bcd
- count_bcd  out  4*DIGITS  running count, digit 0 in [3:0]
- lap_bcd  out  4*DIGITS  last captured count
- lap_valid  out  1  one-cycle pulse, cycle after capture
- tick  out  1  one-cycle pulse on each count increment cycle
- running  out  1  high in RUN
- overflow  out  1  sticky full-scale flag

Behaviour:
- Single clock (clk); reset is synchronous and active-high.
- Reset: state IDLE, prescaler 0, all outputs 0.
- Reset has priority over every other input.
- FSM states and transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE.
  - PAUSE: start -> RUN.
  - clear from any state -> IDLE.
- Control priority within a cycle: reset > clear > stop > start. start and stop together: stop wins; in IDLE, start+stop stays IDLE.
- Prescaler:
  - Counts 0..DIV-1 only in RUN, then wraps to 0.
  - Held (not cleared) in PAUSE, so resume keeps the fractional period.
  - Cleared by reset/clear.
- tick is combinational from registered state: tick = (state==RUN) && (prescaler==DIV-1).
- Increment:
  - On a clock edge with tick=1, count_bcd increments by one decimal unit, visible the next cycle.
  - Each digit counts 0..9; carry ripples to higher digits in the same edge.
  - Digits never hold 10..15.
- stop asserted in a tick cycle: that increment still occurs, then PAUSE.
- Full scale (all digits 9) with tick:
  - WRAP=1: count -> 0, overflow <= 1.
  - WRAP=0: count holds all nines, overflow <= 1, state remains RUN.
  - overflow clears only on reset/clear.
- First increment after start from IDLE occurs DIV cycles after the edge that enters RUN.
- Lap capture:
  - lap=1 in any state: lap_bcd <= count_bcd value pre-increment, even if tick is in the same cycle.
  - lap_valid=1 for exactly the following cycle.
  - Held lap for k cycles: captures every cycle; lap_valid high for k cycles, delayed by 1.
  - clear and lap together: clear wins, lap_bcd = 0, no lap_valid.
- running = (state==RUN), registered.

Test Plan:
- Params CLK_FREQ_HZ=10, TICK_HZ=1 (DIV=10), DIGITS=2, WRAP=1. Reset, start for 1 cycle, run 250 cycles -> count_bcd=8'h25, 25 tick pulses each 10 cycles apart, running=1.
- Same params: count at 8'h99, next tick -> count 8'h00, overflow=1. Further ticks keep overflow=1; clear -> overflow=0, count 0, running=0.
- WRAP=0, count at 8'h99, 3 more ticks -> count stays 8'h99, overflow=1, running=1.
- Pause fraction: start, stop after 7 cycles (prescaler=7), wait 50 cycles, start -> next tick exactly 3 cycles after entering RUN; count unchanged during pause.
- Lap with tick coincident: count 8'h09 and lap asserted in the tick cycle -> lap_bcd=8'h09, count=8'h10, lap_valid high the next cycle only.
- Priorities: start+stop in IDLE -> stays IDLE. stop in tick cycle -> increment then PAUSE. reset asserted mid-RUN with start high -> all outputs 0 the following cycle, state IDLE.

Source files
------------

// File: rtl/bcd_lap_counter.sv
// Stopwatch-style lap counter: prescaled tick, packed-BCD count, run/pause/clear
// control, lap capture and a wrap-or-saturate policy at full scale.
module bcd_lap_counter #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned DIGITS      = 6,
    parameter bit          WRAP        = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [4*DIGITS-1:0]   lap_bcd,
    output logic                  lap_valid,
    output logic                  tick,
    output logic                  running,
    output logic                  overflow
);

    localparam int unsigned DIV = (TICK_HZ == 0) ? 0 : CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = 4 * DIGITS;

    // Refuse to elaborate with a non-integer or too-small divider or bad digit count.
    generate
        if (TICK_HZ == 0 || (CLK_FREQ_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
            $error("bcd_lap_counter: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
        end
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("bcd_lap_counter: DIGITS must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   presc_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_inc;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   lap_q;
    logic            lap_valid_q;
    logic            overflow_q;
    logic            running_q;
    logic            all_nines;
    logic            tick_int;

    assign tick_int = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));

    // Control FSM; stop beats start, clear beats both.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start && !stop) state_d = ST_RUN;
                ST_RUN:   if (stop)           state_d = ST_PAUSE;
                ST_PAUSE: if (start && !stop) state_d = ST_RUN;
                default:                      state_d = ST_IDLE;
            endcase
        end
    end

    // Decimal increment with ripple carry; the final carry flags full scale.
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        count_inc = count_q;
        carry     = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (digit >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = digit + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    always_comb begin
        count_d = count_q;
        if (tick_int) begin
            if (!all_nines) begin
                count_d = count_inc;
            end else if (WRAP) begin
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            count_q     <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            // Prescaler only advances in RUN so a pause keeps the partial period.
            if (state_q == ST_RUN) begin
                presc_q <= tick_int ? '0 : presc_q + PW'(1);
            end
            count_q <= count_d;
            if (tick_int && all_nines) begin
                overflow_q <= 1'b1;
            end
            if (lap) begin
                lap_q <= count_q;
            end
            lap_valid_q <= lap;
        end
    end

    assign count_bcd = count_q;
    assign lap_bcd   = lap_q;
    assign lap_valid = lap_valid_q;
    assign tick      = tick_int;
    assign running   = running_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_lap_counter.sv
// Directed bench for bcd_lap_counter: a wrapping and a saturating instance share
// stimulus and are checked every cycle against an integer-arithmetic model.
module tb_bcd_lap_counter;

    localparam int DIV  = 10;
    localparam int MAXV = 99;

    logic clk = 1'b0;
    logic reset, clear, start, stop, lap;

    logic [7:0] cnt0, lapb0, cnt1, lapb1;
    logic       lv0, tk0, run0, ovf0, lv1, tk1, run1, ovf1;

    int n_cmp = 0;
    int n_err = 0;
    bit model_ok = 1'b0;
    bit done = 1'b0;

    // Model: 0 = idle, 1 = run, 2 = pause; counts kept as plain integers.
    int m_state, m_presc, m_lapv;
    int m_cnt[2], m_lap[2], m_ovf[2];
    bit m_tick;

    always #5 clk = ~clk;

    bcd_lap_counter #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .DIGITS(2), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .stop(stop), .lap(lap),
        .count_bcd(cnt0), .lap_bcd(lapb0), .lap_valid(lv0), .tick(tk0),
        .running(run0), .overflow(ovf0)
    );

    bcd_lap_counter #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .DIGITS(2), .WRAP(1'b0)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .stop(stop), .lap(lap),
        .count_bcd(cnt1), .lap_bcd(lapb1), .lap_valid(lv1), .tick(tk1),
        .running(run1), .overflow(ovf1)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt0(input logic [7:0] v, input int limit);
        for (int i = 0; i < limit && cnt0 !== v; i++) cyc(1);
        chk("wait_count", 32'(cnt0), 32'(v));
    endtask

    always @(posedge clk) begin
        m_tick = (m_state == 1) && (m_presc == DIV - 1);
        if (reset || clear) begin
            if (reset) model_ok = 1'b1;
            m_state = 0;
            m_presc = 0;
            m_lapv  = 0;
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_lap[k] = 0; m_ovf[k] = 0;
            end
        end else begin
            m_lapv = int'(lap);
            for (int k = 0; k < 2; k++) begin
                if (lap) m_lap[k] = m_cnt[k];
                if (m_tick) begin
                    if (m_cnt[k] == MAXV) begin
                        m_cnt[k] = (k == 0) ? 0 : MAXV;
                        m_ovf[k] = 1;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
            if (m_state == 1) m_presc = (m_presc + 1) % DIV;
            case (m_state)
                0:       if (start && !stop) m_state = 1;
                1:       if (stop)           m_state = 2;
                default: if (start && !stop) m_state = 1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_ok && !done) begin
            chk("w.count",     32'(cnt0),  32'(to_bcd(m_cnt[0])));
            chk("w.lap_bcd",   32'(lapb0), 32'(to_bcd(m_lap[0])));
            chk("w.overflow",  32'(ovf0),  32'(m_ovf[0]));
            chk("w.lap_valid", 32'(lv0),   32'(m_lapv));
            chk("w.tick",      32'(tk0),   32'(m_state == 1 && m_presc == DIV - 1));
            chk("w.running",   32'(run0),  32'(m_state == 1));
            chk("s.count",     32'(cnt1),  32'(to_bcd(m_cnt[1])));
            chk("s.lap_bcd",   32'(lapb1), 32'(to_bcd(m_lap[1])));
            chk("s.overflow",  32'(ovf1),  32'(m_ovf[1]));
            chk("s.lap_valid", 32'(lv1),   32'(m_lapv));
            chk("s.tick",      32'(tk1),   32'(m_state == 1 && m_presc == DIV - 1));
            chk("s.running",   32'(run1),  32'(m_state == 1));
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks;
        int last;
        reset = 1'b1; clear = 1'b0; start = 1'b0; stop = 1'b0; lap = 1'b0;
        cyc(3);
        reset = 1'b0;
        chk("rst.count", 32'(cnt0), 32'h0);
        chk("rst.running", 32'(run0), 32'h0);
        chk("rst.overflow", 32'(ovf0), 32'h0);
        chk("rst.lap_valid", 32'(lv0), 32'h0);

        // 250 cycles of RUN gives 25 ticks, 10 cycles apart.
        start = 1'b1; cyc(1); start = 1'b0;
        ticks = 0; last = -1;
        for (int i = 0; i < 250; i++) begin
            if (tk0 === 1'b1) begin
                ticks++;
                if (last >= 0) chk("run.tick_spacing", 32'(i - last), 32'd10);
                last = i;
            end
            cyc(1);
        end
        chk("run.count", 32'(cnt0), 32'h25);
        chk("run.ticks", 32'(ticks), 32'd25);
        chk("run.running", 32'(run0), 32'h1);

        // Full scale: wrap vs saturate.
        wait_cnt0(8'h99, 1000);
        cyc(10);
        chk("fs.wrap_count", 32'(cnt0), 32'h00);
        chk("fs.wrap_ovf", 32'(ovf0), 32'h1);
        chk("fs.sat_count", 32'(cnt1), 32'h99);
        cyc(30);
        chk("fs.wrap_count3", 32'(cnt0), 32'h03);
        chk("fs.wrap_ovf3", 32'(ovf0), 32'h1);
        chk("fs.sat_count3", 32'(cnt1), 32'h99);
        chk("fs.sat_ovf3", 32'(ovf1), 32'h1);
        chk("fs.sat_running", 32'(run1), 32'h1);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("clr.count", 32'(cnt0), 32'h0);
        chk("clr.ovf", 32'(ovf0), 32'h0);
        chk("clr.sat_ovf", 32'(ovf1), 32'h0);
        chk("clr.running", 32'(run0), 32'h0);

        // Pause with prescaler at 7; resume ticks after 3 more cycles.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(6);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("pause.running", 32'(run0), 32'h0);
        cyc(50);
        chk("pause.count", 32'(cnt0), 32'h0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("resume.running", 32'(run0), 32'h1);
        chk("resume.tick0", 32'(tk0), 32'h0);
        cyc(1);
        chk("resume.tick1", 32'(tk0), 32'h0);
        cyc(1);
        chk("resume.tick2", 32'(tk0), 32'h1);
        chk("resume.count2", 32'(cnt0), 32'h0);
        cyc(1);
        chk("resume.count3", 32'(cnt0), 32'h1);

        // Lap coincident with the 09 -> 10 tick.
        wait_cnt0(8'h09, 200);
        cyc(9);
        chk("lap.tick", 32'(tk0), 32'h1);
        lap = 1'b1; cyc(1); lap = 1'b0;
        chk("lap.lap_bcd", 32'(lapb0), 32'h09);
        chk("lap.count", 32'(cnt0), 32'h10);
        chk("lap.valid", 32'(lv0), 32'h1);
        cyc(1);
        chk("lap.valid_drop", 32'(lv0), 32'h0);
        lap = 1'b1; cyc(3); lap = 1'b0;
        chk("lap.held_valid", 32'(lv0), 32'h1);
        cyc(1);
        chk("lap.held_drop", 32'(lv0), 32'h0);

        // stop in a tick cycle: increment 10 -> 11, then PAUSE.
        for (int i = 0; i < 20 && tk0 !== 1'b1; i++) cyc(1);
        chk("stop.tick_wait", 32'(tk0), 32'h1);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("stop.count", 32'(cnt0), 32'h11);
        chk("stop.running", 32'(run0), 32'h0);
        cyc(12);
        chk("stop.count_held", 32'(cnt0), 32'h11);

        // start+stop in IDLE stays IDLE.
        clear = 1'b1; cyc(1); clear = 1'b0;
        start = 1'b1; stop = 1'b1; cyc(2); start = 1'b0; stop = 1'b0;
        chk("both.running", 32'(run0), 32'h0);
        cyc(15);
        chk("both.count", 32'(cnt0), 32'h0);

        // Reset beats a held start mid-RUN.
        start = 1'b1; cyc(25);
        chk("rrun.count", 32'(cnt0), 32'h02);
        reset = 1'b1; cyc(1);
        chk("rrun.count0", 32'(cnt0), 32'h0);
        chk("rrun.lap0", 32'(lapb0), 32'h0);
        chk("rrun.valid0", 32'(lv0), 32'h0);
        chk("rrun.tick0", 32'(tk0), 32'h0);
        chk("rrun.running0", 32'(run0), 32'h0);
        chk("rrun.ovf0", 32'(ovf0), 32'h0);
        reset = 1'b0; start = 1'b0; cyc(2);
        chk("rrun.idle", 32'(run0), 32'h0);

        // clear beats lap.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(30);
        chk("cl.count", 32'(cnt0), 32'h03);
        lap = 1'b1; cyc(1);
        clear = 1'b1; cyc(1); clear = 1'b0; lap = 1'b0;
        chk("cl.lap_bcd", 32'(lapb0), 32'h0);
        chk("cl.valid", 32'(lv0), 32'h0);
        chk("cl.count0", 32'(cnt0), 32'h0);
        cyc(2);

        done = 1'b1;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
